// File: rtl/jtpopeye_pkg.sv
// Shared types and helpers for the Popeye SDRAM programming writer.
package jtpopeye_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_WAIT = 2'd2} wr_st_e;

  localparam logic [1:0] MASK_NONE = 2'b11;

  typedef struct packed {
    logic [21:0] addr;
    logic [15:0] din;
    logic [1:0]  mask;
  } prog_word_t;

  // Byte goes to every lane whose active-low mask bit is clear; other lanes read zero
  function automatic logic [15:0] lane_place(input logic [7:0] data, input logic [1:0] mask);
    lane_place = {mask[1] ? 8'h00 : data, mask[0] ? 8'h00 : data};
  endfunction
endpackage

// File: rtl/jtpopeye_prog_writer_if.sv
// SDRAM write port: request/ack/ready handshake plus the word being written.
interface jtpopeye_prog_writer_if;
  logic [21:0] sdram_addr;
  logic [15:0] sdram_din;
  logic [1:0]  sdram_mask;
  logic        sdram_req;
  logic        sdram_ack;
  logic        sdram_rdy;

  modport master (output sdram_addr, sdram_din, sdram_mask, sdram_req,
                  input  sdram_ack, sdram_rdy);
  modport slave  (input  sdram_addr, sdram_din, sdram_mask, sdram_req,
                  output sdram_ack, sdram_rdy);
endinterface

// File: rtl/jtpopeye_prog_fifo.sv
// Small synchronous FIFO; AW+1 bit pointers, full/empty from the wrap bit.
module jtpopeye_prog_fifo #(
  parameter int AW = 2,
  parameter int DW = 40
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [DW-1:0] i_din,
  output logic [DW-1:0] o_dout,
  output logic          o_full,
  output logic          o_empty
);
  logic [DW-1:0] r_mem [2**AW];
  logic [AW:0]   r_wp, r_rp;
  logic          w_wr, w_rd;

  assign o_empty = (r_wp == r_rp);
  assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_rd    = i_pop && !o_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign w_wr    = i_push && (!o_full || w_rd);
  assign o_dout  = r_mem[r_rp[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + (AW+1)'(1);
      if (w_rd) r_rp <= r_rp + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp[AW-1:0]] <= i_din;
  end
endmodule

// File: rtl/jtpopeye_prog_writer.sv
// Pairs download bytes into 16-bit words, queues them and writes them to SDRAM
// through a req/ack/rdy handshake.
module jtpopeye_prog_writer
  import jtpopeye_pkg::*;
#(
  parameter int AW        = 2,
  parameter int FLUSH_CYC = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_downloading,
  input  logic [21:0] i_prog_addr,
  input  logic [7:0]  i_prog_data,
  input  logic [1:0]  i_prog_mask,
  input  logic        i_prog_we,
  jtpopeye_prog_writer_if.master sd,
  output logic        o_loading,
  output logic        o_overflow
);
  prog_word_t r_hold, r_push_w, w_new, w_head;
  logic       r_hold_v, r_push, r_dl_d, r_loading, r_overflow;
  logic [3:0] r_cnt;
  logic       w_we, w_merge, w_flush, w_full, w_empty, w_pop;
  wr_st_e     r_st, w_st_nx;

  assign w_we = i_prog_we && (i_prog_mask != MASK_NONE);

  always_comb begin
    w_new   = '{addr: i_prog_addr, din: lane_place(i_prog_data, i_prog_mask), mask: i_prog_mask};
    w_merge = r_hold_v && (r_hold.addr == i_prog_addr) && ((r_hold.mask | i_prog_mask) == MASK_NONE);
    // An accepted byte takes priority over the idle/end-of-download flush
    w_flush = r_hold_v && !w_we && (!i_downloading || (r_cnt == 4'(FLUSH_CYC-1)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold   <= '0;
      r_hold_v <= 1'b0;
      r_push   <= 1'b0;
      r_push_w <= '0;
      r_cnt    <= '0;
    end else begin
      r_push <= 1'b0;
      if (w_we) begin
        r_cnt <= '0;
        if (w_merge) begin
          r_push   <= 1'b1;
          r_push_w <= '{addr: r_hold.addr, din: r_hold.din | w_new.din, mask: r_hold.mask & w_new.mask};
          r_hold_v <= 1'b0;
        end else begin
          r_push   <= r_hold_v;
          r_push_w <= r_hold;
          r_hold   <= w_new;
          r_hold_v <= 1'b1;
        end
      end else if (w_flush) begin
        r_push   <= 1'b1;
        r_push_w <= r_hold;
        r_hold_v <= 1'b0;
        r_cnt    <= '0;
      end else if (r_hold_v) begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  jtpopeye_prog_fifo #(.AW(AW), .DW($bits(prog_word_t))) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_push),
    .i_pop   (w_pop),
    .i_din   (r_push_w),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_st <= ST_IDLE;
    else        r_st <= w_st_nx;
  end

  always_comb begin
    w_st_nx = r_st;
    w_pop   = 1'b0;
    case (r_st)
      ST_IDLE: if (!w_empty) w_st_nx = ST_REQ;
      ST_REQ:  if (sd.sdram_ack) begin
                 w_pop   = 1'b1;
                 w_st_nx = sd.sdram_rdy ? ST_IDLE : ST_WAIT;
               end
      ST_WAIT: if (sd.sdram_rdy) w_st_nx = ST_IDLE;
      default: w_st_nx = ST_IDLE;
    endcase
  end

  // Head word is latched when the request starts, so it stays put until ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sd.sdram_req  <= 1'b0;
      sd.sdram_addr <= '0;
      sd.sdram_din  <= '0;
      sd.sdram_mask <= '0;
    end else begin
      sd.sdram_req <= (w_st_nx == ST_REQ);
      if (r_st == ST_IDLE && !w_empty) begin
        sd.sdram_addr <= w_head.addr;
        sd.sdram_din  <= w_head.din;
        sd.sdram_mask <= w_head.mask;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dl_d     <= 1'b0;
      r_loading  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_dl_d    <= i_downloading;
      r_loading <= i_downloading | r_hold_v | !w_empty | (r_st != ST_IDLE);
      if (i_downloading && !r_dl_d)       r_overflow <= 1'b0;
      else if (r_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  assign o_loading  = r_loading;
  assign o_overflow = r_overflow;
endmodule

// File: tb/tb_jtpopeye_prog_writer.sv
// Randomized bench for jtpopeye_prog_writer against a byte-pairing reference model.
module tb_jtpopeye_prog_writer;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int FLUSH = 15;

  logic        clk = 1'b0, rst_n = 1'b0, dl = 1'b0, we = 1'b0;
  logic [21:0] pa = '0;
  logic [7:0]  pd = '0;
  logic [1:0]  pm = 2'b11;
  logic        loading, ovf;

  jtpopeye_prog_writer_if sd ();

  jtpopeye_prog_writer #(.AW(AW), .FLUSH_CYC(FLUSH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_downloading (dl),
    .i_prog_addr   (pa),
    .i_prog_data   (pd),
    .i_prog_mask   (pm),
    .i_prog_we     (we),
    .sd            (sd),
    .o_loading     (loading),
    .o_overflow    (ovf)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model: expected SDRAM writes in order
  logic [39:0] exp_q[$];
  bit          h_v = 0;
  logic [21:0] h_a;
  logic [15:0] h_d;
  logic [1:0]  h_m;
  int          cyc = 0, last_cyc = 0;
  bit          blocked = 0, exp_ovf = 0;
  int          blk_push = 0;

  function automatic void m_push(input logic [21:0] a, input logic [15:0] d, input logic [1:0] m);
    if (blocked && blk_push >= DEPTH) exp_ovf = 1;
    else exp_q.push_back({a, d, m});
    if (blocked) blk_push++;
  endfunction

  function automatic void m_byte(input logic [21:0] a, input logic [7:0] data, input logic [1:0] m);
    logic [15:0] w;
    if (m == 2'b11) return;
    w = '0;
    for (int i = 0; i < 2; i++) if (!m[i]) w = w | (16'(data) << (8*i));
    if (h_v && h_a == a && ((~h_m & ~m) == 2'b00)) begin
      m_push(a, h_d | w, h_m & m);
      h_v = 0;
    end else begin
      if (h_v) m_push(h_a, h_d, h_m);
      h_v = 1; h_a = a; h_d = w; h_m = m;
    end
    last_cyc = cyc;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
    cyc++;
    if (h_v && dl && (cyc - last_cyc - 1) >= FLUSH) begin
      m_push(h_a, h_d, h_m);
      h_v = 0;
    end
  endtask

  task automatic send(input logic [21:0] a, input logic [7:0] d, input logic [1:0] m);
    we = 1; pa = a; pd = d; pm = m;
    m_byte(a, d, m);
    step();
    we = 0;
  endtask

  task automatic fall();
    dl = 0;
    if (h_v) begin m_push(h_a, h_d, h_m); h_v = 0; end
  endtask

  // SDRAM responder and write monitor
  int n_wr = 0, n_rdy = 0, n_reqr = 0, last_hold = 0;
  int ack_dly = 0, rdy_dly = 1;
  bit rnd = 0, ack_block = 0;

  initial begin : resp
    int rs, wc, rc, hl;
    logic prev_req;
    logic [39:0] cur;
    rs = 0; wc = 0; rc = 0; hl = 0; prev_req = 0; cur = '0;
    sd.sdram_ack = 0; sd.sdram_rdy = 0;
    forever begin
      @(negedge clk);
      sd.sdram_ack = 0; sd.sdram_rdy = 0;
      if (!rst_n) begin
        rs = 0; wc = 0; prev_req = 0;
      end else begin
        if (sd.sdram_req) begin
          if (!prev_req) begin
            chk("req_after_rdy", n_rdy, n_reqr);
            n_reqr++; hl = 0;
            cur = {sd.sdram_addr, sd.sdram_din, sd.sdram_mask};
          end else
            chk("req_stable", {sd.sdram_addr, sd.sdram_din, sd.sdram_mask}, cur);
          hl++;
        end
        prev_req = sd.sdram_req;
        if (rs == 0) begin
          if (sd.sdram_req && !ack_block) begin
            if (wc >= ack_dly) begin
              sd.sdram_ack = 1; n_wr++; wc = 0; last_hold = hl;
              chk("wr_expected", exp_q.size() > 0, 1);
              if (exp_q.size() > 0) chk("wr_word", cur, exp_q.pop_front());
              if (rdy_dly == 0) begin sd.sdram_rdy = 1; n_rdy++; end
              else begin rs = 1; rc = 1; end
              if (rnd) begin ack_dly = $urandom_range(0, 1); rdy_dly = $urandom_range(0, 1); end
            end else wc++;
          end
        end else begin
          if (rc >= rdy_dly) begin sd.sdram_rdy = 1; n_rdy++; rs = 0; end
          else rc++;
        end
      end
    end
  end

  task automatic wait_rdy(input string tag, input int target, input int lim);
    for (int i = 0; i < lim && n_rdy < target; i++) step();
    chk(tag, n_rdy, target);
  endtask

  initial begin : main
    int w0, r0;
    #12;
    chk("rst_req",  sd.sdram_req, 0);
    chk("rst_addr", sd.sdram_addr, 0);
    chk("rst_din",  sd.sdram_din, 0);
    chk("rst_mask", sd.sdram_mask, 0);
    chk("rst_load", loading, 0);
    chk("rst_ovf",  ovf, 0);
    step(); rst_n = 1; dl = 1;
    step(); step(); step();

    // merge pair and push/request latency
    w0 = n_wr;
    send(22'h000010, 8'hAB, 2'b01);
    send(22'h000010, 8'hCD, 2'b10);
    chk("lat_n0", sd.sdram_req, 0);
    step(); chk("lat_n1", sd.sdram_req, 0);
    step(); chk("lat_n2", sd.sdram_req, 1);
    wait_rdy("merge_done", w0 + 1, 20);
    step(); step(); step();
    chk("merge_count", n_wr - w0, 1);

    // unpaired byte flushed after idle timeout
    w0 = n_wr; r0 = n_reqr;
    send(22'h000020, 8'h5A, 2'b10);
    for (int i = 0; i < 13; i++) step();
    chk("tmo_early", n_reqr - r0, 0);
    wait_rdy("tmo_done", w0 + 1, 25);

    // delayed ack: request held, next request only after rdy
    ack_dly = 6; rdy_dly = 2; w0 = n_wr;
    send(22'h000040, 8'h11, 2'b00);
    send(22'h000041, 8'h22, 2'b00);
    wait_rdy("hold_done", w0 + 2, 100);
    chk("hold_len", last_hold, 7);
    ack_dly = 0; rdy_dly = 1;

    // randomized traffic
    rnd = 1;
    for (int g = 0; g < 40; g++) begin
      logic [21:0] base;
      base = 22'($urandom) & 22'h3FFFFE;
      send(base | 22'($urandom_range(0, 1)), 8'($urandom), 2'($urandom_range(0, 3)));
      for (int i = $urandom_range(0, 2); i > 0; i--) step();
      send(base | 22'($urandom_range(0, 1)), 8'($urandom), 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1) for (int i = $urandom_range(8, 12); i > 0; i--) step();
      else                           for (int i = $urandom_range(18, 24); i > 0; i--) step();
    end
    for (int i = 0; i < 200 && (h_v || exp_q.size() > 0 || n_rdy != n_wr); i++) step();
    step(); step(); step();
    chk("rnd_drained", exp_q.size(), 0);
    chk("rnd_rdy", n_rdy, n_wr);
    chk("rnd_ovf", ovf, 0);
    rnd = 0; ack_dly = 0; rdy_dly = 1;

    // overflow: ack stalled, six words into a four-deep FIFO
    w0 = n_wr; blocked = 1; blk_push = 0; ack_block = 1;
    for (int i = 0; i < 6; i++) send(22'h000200 + 22'(i), 8'(8'h30 + i), 2'b00);
    for (int i = 0; i < 20; i++) step();
    chk("ovf_set", ovf, exp_ovf);
    chk("ovf_exp", exp_ovf, 1);
    chk("ovf_nowr", n_wr - w0, 0);
    ack_block = 0; blocked = 0;
    wait_rdy("ovf_drain", w0 + 4, 60);
    for (int i = 0; i < 10; i++) step();
    chk("ovf_count", n_wr - w0, 4);
    chk("ovf_sticky", ovf, 1);
    dl = 0; step(); step();
    dl = 1; step(); step();
    chk("ovf_clear", ovf, 0);

    // PROM bytes are ignored; end of download flushes the hold
    w0 = n_wr;
    send(22'h000300, 8'hEE, 2'b11);
    for (int i = 0; i < 25; i++) step();
    chk("prom_nowr", n_wr - w0, 0);
    send(22'h000310, 8'h77, 2'b01);
    step(); step();
    fall();
    wait_rdy("end_flush", w0 + 1, 30);
    chk("load_at_rdy", loading, 1);
    step(); chk("load_hold", loading, 1);
    step(); chk("load_fall", loading, 0);
    chk("end_q", exp_q.size(), 0);

    // async reset in WAIT abandons the write
    dl = 1; step(); step();
    ack_dly = 0; rdy_dly = 8; w0 = n_wr;
    send(22'h000400, 8'h12, 2'b01);
    send(22'h000400, 8'h34, 2'b10);
    for (int i = 0; i < 20 && n_wr == w0; i++) step();
    chk("rst_acked", n_wr - w0, 1);
    step(); step();
    r0 = n_reqr;
    #2 rst_n = 0;
    #1;
    chk("arst_req",  sd.sdram_req, 0);
    chk("arst_addr", sd.sdram_addr, 0);
    chk("arst_din",  sd.sdram_din, 0);
    chk("arst_mask", sd.sdram_mask, 0);
    chk("arst_load", loading, 0);
    chk("arst_ovf",  ovf, 0);
    dl = 0; step(); step(); step();
    rst_n = 1;
    for (int i = 0; i < 30; i++) step();
    chk("arst_noreq", n_reqr - r0, 0);
    chk("arst_idle", loading, 0);
    chk("arst_q", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
